sar_adc: RTL

SAR_ADC -- requirements
Module: sar_adc

---
 rtl/sar_adc_pkg.sv | 20 ++
 rtl/sar_cmp.sv | 27 ++
 rtl/sar_adc.sv | 103 ++++++++++
 3 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the successive-approximation ADC.
// Holds the FSM state encoding and the LSB weight used by the comparator.
package sar_adc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } sar_state_e;

   // Voltage of one code step: fs / 2^nbits.
   function automatic real lsb_weight(input real fs, input int nbits);
      return fs / real'(64'd1 << nbits);
   endfunction

   // Width of the bit-index counter; at least one bit even when nbits == 1.
   function automatic int idx_width(input int nbits);
      return (nbits > 1) ? $clog2(nbits) : 1;
   endfunction

endpackage

// File: rtl/sar_cmp.sv
// Trial-code threshold and analog compare for the SAR loop (combinational).
// SAR_ADC_HALF_LSB_EN shifts the threshold down by half an LSB (round-to-nearest).
module sar_cmp
   import sar_adc_pkg::*;
#(
   parameter int  bits      = 8,
   parameter real fullscale = 1.0
) (
   input  real              vhold,
   input  logic [bits-1:0]  trial,
   output logic             keep
);

   localparam real LSB = lsb_weight(fullscale, bits);

   real thr;

   always_comb begin
`ifdef SAR_ADC_HALF_LSB_EN
      thr  = (real'(trial) - 0.5) * LSB;
`else
      thr  = real'(trial) * LSB;
`endif
      keep = (vhold >= thr);
   end

endmodule

// File: rtl/sar_adc.sv
// Successive-approximation ADC: start in IDLE samples vin, valid pulses bits edges later.
// No backpressure: start is ignored while busy; optional SAR_ADC_HALF_LSB_EN rounds.
module sar_adc
   import sar_adc_pkg::*;
#(
   parameter int  bits      = 8,
   parameter real fullscale = 1.0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  real              vin,
   output logic [bits-1:0]  dout,
   output logic             valid,
   output logic             busy
);

   localparam int              IW      = idx_width(bits);
   localparam logic [IW-1:0]   IDX_TOP = IW'(bits - 1);

   sar_state_e       state_q, state_d;
   logic [bits-1:0]  code_q, code_d;
   logic [bits-1:0]  dout_q, dout_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   real              vhold_q, vhold_d;
   logic [bits-1:0]  trial;
   logic             keep;

   always_comb begin
      trial        = code_q;
      trial[idx_q] = 1'b1;
   end

   sar_cmp #(
      .bits      (bits),
      .fullscale (fullscale)
   ) u_cmp (
      .vhold (vhold_q),
      .trial (trial),
      .keep  (keep)
   );

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      dout_d  = dout_q;
      idx_d   = idx_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      vhold_d = vhold_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               vhold_d = vin;
               code_d  = '0;
               idx_d   = IDX_TOP;
               busy_d  = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            if (keep) code_d = trial;
            if (idx_q == '0) begin
               // Last bit decided this edge, so the result comes straight from keep.
               dout_d  = keep ? trial : code_q;
               valid_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         dout_q  <= '0;
         idx_q   <= IDX_TOP;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         vhold_q <= 0.0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         dout_q  <= dout_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         vhold_q <= vhold_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign busy  = busy_q;

endmodule
